// File: rtl/ring_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_pkg
// Description : Shared constants and helpers for the multi-mode ring counter
// Revision    : 1.0 - initial release
// ============================================================================
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  // Phase index must cover the longest period (Johnson, 2*W steps)
  function automatic int phase_width(input int w);
    return $clog2(2 * w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_legal_check.sv
`default_nettype none
// ============================================================================
// Module      : ring_legal_check
// Description : Combinational legality test of a counter state for the
//               selected mode (one-hot for ring, thermometer for Johnson)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_legal_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic             legal
);

  // Marks every position where two neighbouring bits differ
  logic [WIDTH-2:0] edge_bits;

  assign edge_bits = state[WIDTH-1:1] ^ state[WIDTH-2:0];

  // Ring states are one-hot; Johnson states have at most one 0/1 boundary
  always_comb begin
    legal = 1'b0;
    if (mode == MODE_RING) begin
      legal = ($countones(state) == 1);
    end else begin
      legal = ($countones(edge_bits) <= 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ring_counter_multi.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_multi
// Description : Parametrised ring / Johnson counter with run-time mode and
//               direction select, enable, parallel load, illegal-state
//               detection with optional self-correction, wrap pulse and
//               phase index
// Revision    : 1.0 - initial release
// ============================================================================
module ring_counter_multi
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] INIT        = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit               AUTOCORRECT = 1'b1,
  localparam int              PW          = phase_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] Qn,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [PW-1:0] LAST_RING    = PW'(WIDTH - 1);
  localparam logic [PW-1:0] LAST_JOHNSON = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] qn_q, qn_d;
  logic [WIDTH-1:0] origin_q, origin_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             prev_mode_q, prev_mode_d;

  logic             legal;
  logic             mode_change;
  logic [WIDTH-1:0] base_origin;
  logic [PW-1:0]    base_phase;
  logic [PW-1:0]    phase_last;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] target;

  ring_legal_check #(
    .WIDTH (WIDTH)
  ) u_legal (
    .state (qn_q),
    .mode  (mode),
    .legal (legal)
  );

  assign illegal = ~legal;

  // Mode-change rebase plus the shifted candidate for each mode/direction
  always_comb begin
    mode_change = (mode != prev_mode_q);
    // A mode switch restarts the phase count from the current state
    base_origin = mode_change ? qn_q : origin_q;
    base_phase  = mode_change ? '0   : phase_q;
    phase_last  = (mode == MODE_JOHNSON) ? LAST_JOHNSON : LAST_RING;
    target      = (mode == MODE_JOHNSON) ? '0 : INIT;
    shifted     = qn_q;
    case ({mode, dir})
      {MODE_RING,    DIR_LSB}: shifted = {qn_q[0], qn_q[WIDTH-1:1]};
      {MODE_RING,    DIR_MSB}: shifted = {qn_q[WIDTH-2:0], qn_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_LSB}: shifted = {~qn_q[0], qn_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_MSB}: shifted = {qn_q[WIDTH-2:0], ~qn_q[WIDTH-1]};
      default:                 shifted = qn_q;
    endcase
  end

  // Next state: load > correction > enabled shift > hold
  always_comb begin
    qn_d        = qn_q;
    origin_d    = base_origin;
    phase_d     = base_phase;
    wrap_d      = 1'b0;
    prev_mode_d = mode;
    if (load) begin
      qn_d     = D;
      origin_d = D;
      phase_d  = '0;
    end else if (AUTOCORRECT && en && illegal) begin
      qn_d     = target;
      origin_d = target;
      phase_d  = '0;
    end else if (en) begin
      qn_d    = shifted;
      phase_d = (base_phase == phase_last) ? '0 : base_phase + PW'(1);
      wrap_d  = (shifted == base_origin);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qn_q        <= INIT;
      origin_q    <= INIT;
      phase_q     <= '0;
      wrap_q      <= 1'b0;
      prev_mode_q <= MODE_RING;
    end else begin
      qn_q        <= qn_d;
      origin_q    <= origin_d;
      phase_q     <= phase_d;
      wrap_q      <= wrap_d;
      prev_mode_q <= prev_mode_d;
    end
  end

  assign Qn    = qn_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_counter_multi
// Description : Self-checking bench for ring_counter_multi; two instances
//               (self-correcting and non-correcting) share the stimulus and
//               are each compared with a behavioural model every cycle
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter_multi;

  localparam int W      = 4;
  localparam int PW     = 3;
  localparam int FULL   = (1 << W) - 1;
  localparam int INIT_M = 8;

  logic          clk = 1'b0;
  logic          rst, en, load, mode, dir;
  logic [W-1:0]  D;
  logic [W-1:0]  qn_a, qn_b;
  logic [PW-1:0] ph_a, ph_b;
  logic          wr_a, wr_b, il_a, il_b;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = self-correcting instance, 1 = non-correcting
  int m_q[2], m_org[2], m_ph[2];
  bit m_wr[2], m_pm[2];

  always #5 clk = ~clk;

  ring_counter_multi #(.WIDTH(W), .INIT(4'b1000), .AUTOCORRECT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .D(D), .mode(mode), .dir(dir),
    .Qn(qn_a), .phase(ph_a), .wrap(wr_a), .illegal(il_a));

  ring_counter_multi #(.WIDTH(W), .INIT(4'b1000), .AUTOCORRECT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .D(D), .mode(mode), .dir(dir),
    .Qn(qn_b), .phase(ph_b), .wrap(wr_b), .illegal(il_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ring legal = exactly one bit; Johnson legal = a thermometer code
  // (a contiguous run of ones anchored at either end, incl. all-0/all-1)
  function automatic bit legal_m(input int q, input bit md);
    if (!md) return ($countones(q) == 1);
    for (int k = 0; k <= W; k++)
      if (q == (FULL >> k) || q == ((FULL << k) & FULL)) return 1'b1;
    return 1'b0;
  endfunction

  // One step: rotate toward LSB or MSB; Johnson feeds back the inverted bit
  function automatic int step_m(input int q, input bit md, input bit dr);
    int fb;
    if (!dr) begin
      fb = md ? ((q & 1) ^ 1) : (q & 1);
      return (q >> 1) | (fb << (W - 1));
    end
    fb = md ? (((q >> (W - 1)) & 1) ^ 1) : ((q >> (W - 1)) & 1);
    return ((q << 1) & FULL) | fb;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = INIT_M; m_org[k] = INIT_M; m_ph[k] = 0; m_wr[k] = 0; m_pm[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int q   = m_q[k];
    int org = m_org[k];
    int ph  = m_ph[k];
    int per = mode ? 2 * W : W;
    bit wr  = 0;
    if (load) begin
      q = int'(D); org = q; ph = 0;
    end else begin
      if (mode != m_pm[k]) begin org = q; ph = 0; end
      if (en && k == 0 && !legal_m(q, mode)) begin
        q = mode ? 0 : INIT_M; org = q; ph = 0;
      end else if (en) begin
        q = step_m(q, mode, dir); ph = (ph + 1) % per; wr = (q == org);
      end
    end
    m_q[k] = q; m_org[k] = org; m_ph[k] = ph; m_wr[k] = wr; m_pm[k] = mode;
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, ".a.qn"},  32'(qn_a), 32'(m_q[0]));
    check_val({tag, ".a.ph"},  32'(ph_a), 32'(m_ph[0]));
    check_val({tag, ".a.wr"},  32'(wr_a), 32'(m_wr[0]));
    check_val({tag, ".a.ill"}, 32'(il_a), 32'(!legal_m(m_q[0], mode)));
    check_val({tag, ".b.qn"},  32'(qn_b), 32'(m_q[1]));
    check_val({tag, ".b.ph"},  32'(ph_b), 32'(m_ph[1]));
    check_val({tag, ".b.wr"},  32'(wr_b), 32'(m_wr[1]));
    check_val({tag, ".b.ill"}, 32'(il_b), 32'(!legal_m(m_q[1], mode)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_model(tag);
  endtask

  // Direct spec-derived expectation on the self-correcting instance
  task automatic expect_a(input string tag, input int q, input int ph, input bit wr);
    check_val({tag, ".qn"}, 32'(qn_a), 32'(q));
    check_val({tag, ".ph"}, 32'(ph_a), 32'(ph));
    check_val({tag, ".wr"}, 32'(wr_a), 32'(wr));
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_model(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    int exp_q[$];
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; dir = 1'b0; D = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 compare_model("reset");
    expect_a("reset", 8, 0, 0);
    #1 rst = 1'b1;

    // Ring toward LSB
    en = 1'b1;
    exp_q = '{4, 2, 1, 8};
    for (int i = 0; i < 4; i++) begin
      tick("s1");
      expect_a($sformatf("s1.%0d", i), exp_q[i], (i + 1) % 4, i == 3);
    end

    // Ring toward MSB, then direction flips mid-run
    dir = 1'b1;
    exp_q = '{1, 2, 4, 8};
    for (int i = 0; i < 4; i++) begin
      tick("s2");
      expect_a($sformatf("s2.%0d", i), exp_q[i], (i + 1) % 4, i == 3);
    end
    exp_q = '{1, 2, 1, 8};
    for (int i = 0; i < 4; i++) begin
      dir = (i < 2);
      tick("s2b");
      expect_a($sformatf("s2b.%0d", i), exp_q[i], (i + 1) % 4, i == 3);
    end

    // Johnson from all-zero
    load = 1'b1; D = 4'b0000; mode = 1'b1; en = 1'b0; dir = 1'b0;
    tick("s3ld");
    load = 1'b0; en = 1'b1;
    exp_q = '{8, 12, 14, 15, 7, 3, 1, 0};
    for (int i = 0; i < 8; i++) begin
      tick("s3");
      expect_a($sformatf("s3.%0d", i), exp_q[i], (i + 1) % 8, i == 7);
    end

    // Illegal ring load; corrected only by the self-correcting instance
    load = 1'b1; D = 4'b1010; mode = 1'b0; en = 1'b0;
    tick("s4ld");
    check_val("s4.ill_a", 32'(il_a), 32'd1);
    load = 1'b0; en = 1'b1;
    tick("s4");
    expect_a("s4", 8, 0, 0);
    check_val("s4.ill_a2", 32'(il_a), 32'd0);
    check_val("s4.qn_b",   32'(qn_b), 32'h5);
    check_val("s4.ill_b",  32'(il_b), 32'd1);

    // Enable freeze and load priority
    tick("s5a");
    expect_a("s5a", 4, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("s5h");
      expect_a($sformatf("s5h.%0d", i), 4, 1, 0);
    end
    load = 1'b1; D = 4'b0010;
    tick("s5l");
    expect_a("s5l", 2, 0, 0);
    en = 1'b1; D = 4'b0100;
    tick("s5le");
    expect_a("s5le", 4, 0, 0);

    // Async reset mid-sequence, then mode flip ring -> Johnson
    D = 4'b1000;
    tick("s6ld");
    load = 1'b0;
    tick("s6a");
    tick("s6b");
    expect_a("s6b", 2, 2, 0);
    async_reset("s6rst");
    expect_a("s6rst", 8, 0, 0);
    mode = 1'b1; en = 1'b0;
    tick("s6m");
    expect_a("s6m", 8, 0, 0);
    check_val("s6m.ill", 32'(il_a), 32'd0);
    en = 1'b1;
    tick("s6j");
    expect_a("s6j", 12, 1, 0);

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 9) == 0);
      D    = W'($urandom);
      dir  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) async_reset("rnd.rst");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_counter_multi.md
Name: ring_counter_multi

Overview:
- Parametrised successor to the 4-bit loadable ring counter.
- Generalises the block in three ways:
  - WIDTH is a parameter.
  - Ring or Johnson (twisted-ring) mode is selected at run time.
  - Shift direction is selectable.
- Adds an enable input, illegal-state detection with optional self-correction, a wrap pulse and a phase index.
- Used as a one-hot or thermometer sequencer / phase generator feeding downstream control logic.

Parameters:
- WIDTH, 4, number of state bits; must be >= 2.
- INIT, {1'b1,{WIDTH-1{1'b0}}}, reset/origin pattern for ring mode; must be one-hot at MSB or LSB.
- AUTOCORRECT, 1, 1 = illegal states are replaced on the next enabled cycle; 0 = illegal states shift unchanged.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  advance enable
- load  input  1  synchronous parallel load
- D  input  WIDTH  load value
- mode  input  1  0 = ring, 1 = Johnson
- dir  input  1  0 = shift toward LSB, 1 = shift toward MSB
- Qn  output  WIDTH  counter state (registered)
- phase  output  $clog2(2*WIDTH)  steps since origin, modulo the period
- wrap  output  1  one-cycle pulse when Qn returns to origin
- illegal  output  1  combinational: Qn is not legal for the current mode

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - Qn=INIT, origin register=INIT, phase=0, wrap=0, prev_mode=0.
- Priority per rising edge: load > correction > en shift > hold.
- Load (load=1, en ignored):
  - Qn<=D, origin<=D, phase<=0, wrap<=0.
  - D is accepted even if illegal.
- Legality:
  - Ring mode: Qn has exactly one bit set.
  - Johnson mode: at most one adjacent-bit transition across Qn[WIDTH-1:0]. This includes all-0 and all-1; the check is direction independent.
  - illegal = !legal(Qn, mode), evaluated combinationally.
- Correction (AUTOCORRECT=1, en=1, load=0, illegal=1):
  - Qn<=target, origin<=target, phase<=0, wrap<=0.
  - target is INIT in ring mode and all-zero in Johnson mode.
- Shift (en=1, load=0, no correction):
  - Ring, dir=0: Qn<={Qn[0],Qn[WIDTH-1:1]}.
  - Ring, dir=1: Qn<={Qn[WIDTH-2:0],Qn[WIDTH-1]}.
  - Johnson, dir=0: Qn<={~Qn[0],Qn[WIDTH-1:1]}.
  - Johnson, dir=1: Qn<={Qn[WIDTH-2:0],~Qn[WIDTH-1]}.
  - Period P = WIDTH in ring mode, 2*WIDTH in Johnson mode.
  - phase<=(phase==P-1)?0:phase+1. phase counts steps and is direction independent.
  - wrap<=(next Qn==origin). This is registered, so wrap is high in the same cycle Qn shows origin.
- Hold (en=0, load=0): Qn, origin and phase hold; wrap<=0.
- Mode change:
  - prev_mode is registered each cycle. If mode!=prev_mode on an edge without load, phase<=0 and origin<=Qn before the shift is applied.
  - If the state is illegal in the new mode, correction applies per the rules above.
- Direction change mid-run is legal: phase keeps counting; wrap still compares against origin.
- AUTOCORRECT=0: illegal states shift by the mode rule. phase still counts modulo P; wrap still compares against origin.
- All outputs except illegal are registered.

Decomposition:
- Package ring_counter_pkg:
  - mode constants MODE_RING=1'b0, MODE_JOHNSON=1'b1
  - direction constants DIR_LSB=1'b0, DIR_MSB=1'b1
  - function phase_width(W) returning $clog2(2*W)
- Sub-module ring_legal_check (parameter WIDTH): combinational; inputs state and mode, output legal. Instantiated once; also reusable by the bench scoreboard.

Test Plan:
All scenarios use WIDTH=4, INIT=1000, AUTOCORRECT=1 unless noted.
1. rst=0 then 1; en=1, mode=0, dir=0 -> Qn 0100, 0010, 0001, 1000 on successive edges; phase 1, 2, 3, 0; wrap=1 only with the final 1000.
2. Ring, dir=1, from 1000 -> Qn 0001, 0010, 0100, 1000; wrap on the 4th edge; switch dir after 2 steps -> 0001, 0010, 0001, 1000.
3. load D=0000 with mode=1, then en=1, dir=0 -> Qn 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; phase 1..7, 0; wrap with 0000 only.
4. load D=1010 in ring mode -> illegal=1 right after the load edge; next en edge -> Qn=1000, phase=0, wrap=0, illegal=0. Repeat with AUTOCORRECT=0 -> Qn=0101, illegal stays 1.
5. en=0 for 3 cycles -> Qn and phase frozen, wrap=0. load=1 with en=0 -> D loaded. load=1 with en=1 and D=0100 -> Qn=0100, no shift.
6. Drop rst between clock edges mid-sequence (Qn=0010, phase=2) -> Qn=1000, phase=0, wrap=0 immediately. Mode flip from 1000 ring to Johnson -> phase=0, no correction (1000 is legal); Qn=1100 on the next edge.
